// File: rtl/watchdog_ms.sv
// Multi-stage windowed watchdog: prescaled down-counter, NUM_INTR interrupt stages, then timeout.
// Optional configuration lock is compiled in with `define WDT_LOCK_EN.
`timescale 1ns/1ps
module watchdog_ms #(
    parameter int WIDTH    = 32,
    parameter int PRE_W    = 8,
    parameter int NUM_INTR = 1,
    parameter int STG_W    = 2
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             enable,
    input  logic             feed,
    input  logic             update,
    input  logic [WIDTH-1:0] start_value,
    input  logic [WIDTH-1:0] window_value,
    input  logic [PRE_W-1:0] prescale,
    output logic             intr,
    output logic             timeout,
    output logic             early_fault,
    output logic [WIDTH-1:0] count_out,
    output logic [STG_W-1:0] stage_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        TIMEOUT = 2'd2
    } state_t;

    localparam logic [STG_W-1:0] STG_MAX = STG_W'(NUM_INTR);

    generate
        if (WIDTH < 4) begin : g_bad_width
            $error("watchdog_ms: WIDTH must be >= 4");
        end
        if (NUM_INTR >= (2 ** STG_W)) begin : g_bad_stage
            $error("watchdog_ms: NUM_INTR must be < 2**STG_W");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic [STG_W-1:0]   stage_q, stage_d;
    logic               intr_q, intr_d;
    logic               timeout_q, timeout_d;
    logic               early_q, early_d;
    logic               tick;

    // Effective configuration: live inputs, or frozen shadows once locked.
    logic               enable_eff;
    logic [WIDTH-1:0]   start_eff;
    logic [WIDTH-1:0]   window_eff;
    logic [PRE_W-1:0]   prescale_eff;

`ifdef WDT_LOCK_EN
    logic               lock_q;
    logic               lock_set;
    logic [WIDTH-1:0]   start_sh;
    logic [WIDTH-1:0]   window_sh;
    logic [PRE_W-1:0]   prescale_sh;

    assign lock_set = (state_q == IDLE) && enable && !lock_q;

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            lock_q <= 1'b0;
        end else if (lock_set) begin
            lock_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (lock_set) begin
            start_sh    <= start_value;
            window_sh   <= window_value;
            prescale_sh <= prescale;
        end
    end

    assign enable_eff   = lock_q ? 1'b1        : enable;
    assign start_eff    = lock_q ? start_sh    : start_value;
    assign window_eff   = lock_q ? window_sh   : window_value;
    assign prescale_eff = lock_q ? prescale_sh : prescale;
`else
    assign enable_eff   = enable;
    assign start_eff    = start_value;
    assign window_eff   = window_value;
    assign prescale_eff = prescale;
`endif

    assign tick = (pre_cnt_q == prescale_eff);

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state_q   <= IDLE;
            count_q   <= '1;
            pre_cnt_q <= '0;
            stage_q   <= '0;
            intr_q    <= 1'b0;
            timeout_q <= 1'b0;
            early_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pre_cnt_q <= pre_cnt_d;
            stage_q   <= stage_d;
            intr_q    <= intr_d;
            timeout_q <= timeout_d;
            early_q   <= early_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pre_cnt_d = pre_cnt_q;
        stage_d   = stage_q;
        intr_d    = intr_q;
        timeout_d = timeout_q;
        early_d   = early_q;

        case (state_q)
            IDLE: begin
                pre_cnt_d = '0;
                if (enable_eff) begin
                    count_d = start_eff;
                    state_d = COUNT;
                end
            end

            COUNT: begin
                pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
                if (!enable_eff) begin
                    state_d   = IDLE;
                    pre_cnt_d = '0;
                    stage_d   = '0;
                    intr_d    = 1'b0;
                    early_d   = 1'b0;
                end else if (feed) begin
                    // An all-ones window can never be exceeded, so it disables the check.
                    if (count_q > window_eff) begin
                        early_d   = 1'b1;
                        timeout_d = 1'b1;
                        state_d   = TIMEOUT;
                    end else begin
                        count_d   = start_eff;
                        pre_cnt_d = '0;
                        stage_d   = '0;
                        intr_d    = 1'b0;
                    end
                end else if (update) begin
                    count_d   = start_eff;
                    pre_cnt_d = '0;
                end else if (tick) begin
                    if (count_q != '0) begin
                        count_d = count_q - 1'b1;
                    end else if (stage_q < STG_MAX) begin
                        stage_d = stage_q + 1'b1;
                        intr_d  = 1'b1;
                        count_d = start_eff;
                    end else begin
                        timeout_d = 1'b1;
                        state_d   = TIMEOUT;
                    end
                end
            end

            TIMEOUT: begin
                pre_cnt_d = '0;
                if (!enable_eff) begin
                    state_d   = IDLE;
                    timeout_d = 1'b0;
                    intr_d    = 1'b0;
                    early_d   = 1'b0;
                    stage_d   = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign intr        = intr_q;
    assign timeout     = timeout_q;
    assign early_fault = early_q;
    assign count_out   = count_q;
    assign stage_out   = stage_q;

endmodule

// File: tb/tb_watchdog_ms.sv
// Self-checking bench for watchdog_ms: directed scenarios plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_watchdog_ms;

    localparam int WIDTH    = 8;
    localparam int PRE_W    = 4;
    localparam int NUM_INTR = 1;
    localparam int STG_W    = 2;

    logic             clk = 1'b0;
    logic             rst_ = 1'b0;
    logic             enable = 1'b0;
    logic             feed = 1'b0;
    logic             update = 1'b0;
    logic [WIDTH-1:0] start_value = '0;
    logic [WIDTH-1:0] window_value = '1;
    logic [PRE_W-1:0] prescale = '0;
    logic             intr;
    logic             timeout;
    logic             early_fault;
    logic [WIDTH-1:0] count_out;
    logic [STG_W-1:0] stage_out;

    int checks = 0;
    int failures = 0;

    watchdog_ms #(.WIDTH(WIDTH), .PRE_W(PRE_W), .NUM_INTR(NUM_INTR), .STG_W(STG_W)) dut (
        .clk(clk), .rst_(rst_), .enable(enable), .feed(feed), .update(update),
        .start_value(start_value), .window_value(window_value), .prescale(prescale),
        .intr(intr), .timeout(timeout), .early_fault(early_fault),
        .count_out(count_out), .stage_out(stage_out)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode 0 = stopped, 1 = counting, 2 = timed out.
    int m_mode, m_count, m_pre, m_stage;
    bit m_intr, m_to, m_ef;
    bit m_lock;
    int m_ss, m_sw, m_sp;

    task automatic model_reset();
        m_mode = 0; m_count = (1 << WIDTH) - 1; m_pre = 0; m_stage = 0;
        m_intr = 0; m_to = 0; m_ef = 0; m_lock = 0;
    endtask

    task automatic model_step();
        int s, w, p;
        bit e, tk;
        s = int'(start_value); w = int'(window_value); p = int'(prescale); e = enable;
        if (m_lock) begin
            s = m_ss; w = m_sw; p = m_sp; e = 1'b1;
        end
        if (m_mode == 0) begin
            m_pre = 0;
            if (e) begin
                m_count = s; m_mode = 1;
`ifdef WDT_LOCK_EN
                m_lock = 1; m_ss = s; m_sw = w; m_sp = p;
`endif
            end
        end else if (m_mode == 1) begin
            tk = (m_pre == p);
            m_pre = tk ? 0 : m_pre + 1;
            if (!e) begin
                m_mode = 0; m_stage = 0; m_intr = 0; m_ef = 0; m_pre = 0;
            end else if (feed) begin
                if (m_count > w) begin
                    m_ef = 1; m_to = 1; m_mode = 2;
                end else begin
                    m_count = s; m_pre = 0; m_stage = 0; m_intr = 0;
                end
            end else if (update) begin
                m_count = s; m_pre = 0;
            end else if (tk) begin
                if (m_count > 0) m_count = m_count - 1;
                else if (m_stage < NUM_INTR) begin
                    m_stage++; m_intr = 1; m_count = s;
                end else begin
                    m_to = 1; m_mode = 2;
                end
            end
        end else begin
            if (!e) begin
                m_mode = 0; m_to = 0; m_intr = 0; m_ef = 0; m_stage = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst_ = 1'b1;
        model_reset();
        #12;
        checks++; if (count_out !== 8'hFF) begin failures++; $display("FAIL reset_count got=%0d exp=255", count_out); end
        checks++; if ({intr, timeout, early_fault, stage_out} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {intr, timeout, early_fault, stage_out}); end
        @(posedge clk); #3;
        rst_ = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_expiry();
        start_value = 8'd5; prescale = 4'd0; window_value = 8'hFF; enable = 1'b1;
        step();
        checks++; if (count_out !== 8'd5) begin failures++; $display("FAIL expiry_load got=%0d exp=5", count_out); end
        steps(5);
        checks++; if (intr !== 1'b0 || count_out !== 8'd0) begin failures++; $display("FAIL expiry_pre got=%b/%0d exp=0/0", intr, count_out); end
        step();
        checks++; if (intr !== 1'b1 || stage_out !== 2'd1 || count_out !== 8'd5) begin failures++; $display("FAIL expiry_first got=%b/%0d/%0d exp=1/1/5", intr, stage_out, count_out); end
        steps(5);
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL expiry_to_early got=%b exp=0", timeout); end
        step();
        checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL expiry_to_12 got=%b exp=1", timeout); end
    endtask

    task automatic test_feed();
        int bad;
        enable = 1'b0;
        step();
        checks++; if (timeout !== 1'b0 || intr !== 1'b0 || stage_out !== 2'd0) begin failures++; $display("FAIL timeout_exit got=%b/%b/%0d exp=0/0/0", timeout, intr, stage_out); end
        enable = 1'b1;
        steps(10);
        checks++; if (count_out !== 8'd2 || intr !== 1'b1) begin failures++; $display("FAIL feed_pre got=%0d/%b exp=2/1", count_out, intr); end
        feed = 1'b1; step(); feed = 1'b0;
        checks++; if (count_out !== 8'd5 || stage_out !== 2'd0 || intr !== 1'b0) begin failures++; $display("FAIL feed_reload got=%0d/%0d/%b exp=5/0/0", count_out, stage_out, intr); end
        bad = 0;
        for (int i = 0; i < 6; i++) begin step(); if (timeout !== 1'b0) bad++; end
        checks++; if (bad != 0) begin failures++; $display("FAIL feed_no_timeout got=%0d exp=0", bad); end
    endtask

    task automatic test_window();
        enable = 1'b0; step();
        window_value = 8'd3; start_value = 8'd10; enable = 1'b1;
        steps(4);
        checks++; if (count_out !== 8'd7) begin failures++; $display("FAIL window_pre got=%0d exp=7", count_out); end
        feed = 1'b1; step(); feed = 1'b0;
        checks++; if (early_fault !== 1'b1 || timeout !== 1'b1) begin failures++; $display("FAIL window_early got=%b/%b exp=1/1", early_fault, timeout); end
        enable = 1'b0; step();
        checks++; if (early_fault !== 1'b0 || timeout !== 1'b0) begin failures++; $display("FAIL window_clear got=%b/%b exp=0/0", early_fault, timeout); end
        enable = 1'b1;
        steps(8);
        checks++; if (count_out !== 8'd3) begin failures++; $display("FAIL window_open_pre got=%0d exp=3", count_out); end
        feed = 1'b1; step(); feed = 1'b0;
        checks++; if (count_out !== 8'd10 || early_fault !== 1'b0 || timeout !== 1'b0) begin failures++; $display("FAIL window_ok got=%0d/%b/%b exp=10/0/0", count_out, early_fault, timeout); end
    endtask

    task automatic test_prescale();
        enable = 1'b0; step();
        window_value = 8'hFF; start_value = 8'd2; prescale = 4'd3; enable = 1'b1;
        step(); steps(3);
        checks++; if (count_out !== 8'd2) begin failures++; $display("FAIL pre_c3 got=%0d exp=2", count_out); end
        step();
        checks++; if (count_out !== 8'd1) begin failures++; $display("FAIL pre_c4 got=%0d exp=1", count_out); end
        steps(3);
        checks++; if (count_out !== 8'd1) begin failures++; $display("FAIL pre_c7 got=%0d exp=1", count_out); end
        step();
        checks++; if (count_out !== 8'd0) begin failures++; $display("FAIL pre_c8 got=%0d exp=0", count_out); end
        steps(3);
        checks++; if (intr !== 1'b0) begin failures++; $display("FAIL pre_c11 got=%b exp=0", intr); end
        step();
        checks++; if (intr !== 1'b1 || count_out !== 8'd2) begin failures++; $display("FAIL pre_c12 got=%b/%0d exp=1/2", intr, count_out); end
    endtask

    task automatic test_boundaries();
        enable = 1'b0; step();
        prescale = 4'd0; start_value = 8'd2; enable = 1'b1;
        steps(3);
        checks++; if (count_out !== 8'd0) begin failures++; $display("FAIL bnd_zero got=%0d exp=0", count_out); end
        feed = 1'b1; step(); feed = 1'b0;
        checks++; if (count_out !== 8'd2 || intr !== 1'b0 || stage_out !== 2'd0) begin failures++; $display("FAIL bnd_feed_vs_expiry got=%0d/%b/%0d exp=2/0/0", count_out, intr, stage_out); end
        steps(4);
        checks++; if (count_out !== 8'd1 || intr !== 1'b1) begin failures++; $display("FAIL bnd_after_intr got=%0d/%b exp=1/1", count_out, intr); end
        start_value = 8'd4; update = 1'b1; step(); update = 1'b0;
        checks++; if (count_out !== 8'd4 || intr !== 1'b1 || stage_out !== 2'd1) begin failures++; $display("FAIL bnd_update got=%0d/%b/%0d exp=4/1/1", count_out, intr, stage_out); end
        feed = 1'b1; update = 1'b1; step(); feed = 1'b0; update = 1'b0;
        checks++; if (intr !== 1'b0 || stage_out !== 2'd0) begin failures++; $display("FAIL bnd_feed_update got=%b/%0d exp=0/0", intr, stage_out); end
        enable = 1'b0; step();
        start_value = 8'd0; enable = 1'b1;
        steps(2);
        checks++; if (intr !== 1'b1 || timeout !== 1'b0 || count_out !== 8'd0) begin failures++; $display("FAIL bnd_s0_first got=%b/%b/%0d exp=1/0/0", intr, timeout, count_out); end
        step();
        checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL bnd_s0_second got=%b exp=1", timeout); end
        enable = 1'b0; step();
        checks++; if (timeout !== 1'b0 || stage_out !== 2'd0) begin failures++; $display("FAIL bnd_exit got=%b/%0d exp=0/0", timeout, stage_out); end
    endtask

`ifdef WDT_LOCK_EN
    task automatic test_lock();
        start_value = 8'd5; prescale = 4'd0; window_value = 8'hFF; enable = 1'b1;
        step();
        enable = 1'b0; start_value = 8'd99;
        steps(3);
        checks++; if (count_out !== 8'd2) begin failures++; $display("FAIL lock_run got=%0d exp=2", count_out); end
        steps(3);
        checks++; if (count_out !== 8'd5 || intr !== 1'b1) begin failures++; $display("FAIL lock_reload got=%0d/%b exp=5/1", count_out, intr); end
    endtask
`endif

    task automatic test_async_reset();
        enable = 1'b1; start_value = 8'd9; prescale = 4'd0; window_value = 8'hFF;
        steps(4);
        #2;
        rst_ = 1'b1;
        #1;
        model_reset();
        checks++; if (count_out !== 8'hFF || {intr, timeout, early_fault, stage_out} !== 5'b0) begin failures++; $display("FAIL async_reset got=%0d/%b exp=255/00000", count_out, {intr, timeout, early_fault, stage_out}); end
        enable = 1'b0;
        #3;
        rst_ = 1'b0;
        step();
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 24) == 0) enable = ~enable;
            feed   = ($urandom_range(0, 7) == 0);
            update = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) start_value = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 15) == 0) prescale = 4'($urandom_range(0, 2));
            if ($urandom_range(0, 15) == 0) window_value = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom_range(0, 6));
            step();
            checks++;
            if ({count_out, stage_out, intr, timeout, early_fault} !==
                {8'(m_count), 2'(m_stage), m_intr, m_to, m_ef}) begin
                failures++;
                if (bad < 10) $display("FAIL random_cycle%0d got=%0d/%0d/%b%b%b exp=%0d/%0d/%b%b%b", i,
                    count_out, stage_out, intr, timeout, early_fault, m_count, m_stage, m_intr, m_to, m_ef);
                bad++;
            end
        end
        feed = 1'b0; update = 1'b0;
    endtask

    initial begin
        test_reset();
`ifdef WDT_LOCK_EN
        test_lock();
`else
        test_expiry();
        test_feed();
        test_window();
        test_prescale();
        test_boundaries();
`endif
        test_async_reset();
        start_value = 8'd3; window_value = 8'hFF; prescale = 4'd0;
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/watchdog_ms.md
Name: watchdog_ms

Overview:
- Parametrised multi-stage windowed watchdog; successor to the single-counter watchdog used beside the APB register block.
- Generic counter width, prescaler, N interrupt stages before reset, and a feed window (early-feed detection).
- Register block drives the config and strobes; intr goes to the interrupt controller, timeout to the reset generator.

Parameters:
- WIDTH, 32, counter and start/window value width (>=4).
- PRE_W, 8, prescaler compare width.
- NUM_INTR, 1, expiries that raise intr before the next expiry raises timeout (0 = first expiry resets).
- STG_W, 2, stage counter width; must satisfy NUM_INTR < 2**STG_W.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_  in  1  asynchronous, active-high reset (1 = reset).
- enable  in  1  level; watchdog runs while 1.
- feed  in  1  one-cycle strobe; reloads counter, clears escalation.
- update  in  1  one-cycle strobe; reloads counter only.
- start_value  in  WIDTH  reload value.
- window_value  in  WIDTH  feed accepted only when count <= window_value; all-ones disables the window check.
- prescale  in  PRE_W  tick every prescale+1 clocks.
- intr  out  1  sticky interrupt.
- timeout  out  1  reset request.
- early_fault  out  1  sticky; set on a too-early feed.
- count_out  out  WIDTH  current count.
- stage_out  out  STG_W  expiries since the last feed.

Behaviour:
- Reset values: state IDLE, count all-ones, pre_cnt 0, stage 0, intr 0, timeout 0, early_fault 0.
- Tick: pre_cnt increments each COUNT cycle. When pre_cnt==prescale, pre_cnt<=0 and tick=1 that cycle. prescale=0 gives a tick every cycle.
- States: IDLE, COUNT, TIMEOUT.
- IDLE:
  - count frozen, pre_cnt held 0.
  - enable=1: count<=start_value, go to COUNT next cycle.
- COUNT, per cycle, in priority order:
  - (1) enable=0: go to IDLE; stage, intr and early_fault cleared; count held.
  - (2) feed:
    - If count > window_value: early_fault<=1, timeout<=1, go to TIMEOUT.
    - Else: count<=start_value, pre_cnt<=0, stage<=0, intr<=0.
  - (3) update: count<=start_value, pre_cnt<=0; stage and intr unchanged; no window check.
  - (4) tick with count!=0: count<=count-1.
  - (5) tick with count==0 (expiry):
    - stage<NUM_INTR: stage<=stage+1, intr<=1, count<=start_value.
    - stage==NUM_INTR: timeout<=1, go to TIMEOUT.
- TIMEOUT:
  - timeout held 1; feed and update ignored; count held.
  - Exit only via enable=0: go to IDLE, timeout<=0, intr<=0, early_fault<=0, stage<=0. Or via rst_.
- Latency:
  - Registered outputs update the cycle after the causing edge.
  - With start_value=S and prescale=P, the first expiry comes (S+1)*(P+1) clocks after entering COUNT.
- Boundaries:
  - start_value=0 expires on every tick.
  - feed and expiry in the same cycle: feed wins.
  - feed and update together: feed wins.
  - Config inputs are sampled live: a start_value change takes effect at the next reload; a prescale change takes effect at the next compare.
  - Counter never wraps: the decrement is gated by count!=0.
  - rst_ mid-count: immediate return to reset values, independent of clk.

Optional Feature:
- WDT_LOCK_EN.
- Defined:
  - Internal lock bit set on the first IDLE->COUNT transition.
  - While locked, enable=0 is ignored (cannot stop or leave TIMEOUT); start_value, window_value and prescale are captured into shadow registers at lock and the live inputs are ignored.
  - Only rst_ clears the lock.
- Not defined: no lock bit or shadow registers; behaviour exactly as above.

Test Plan:
- NUM_INTR=1, prescale=0, start_value=5, enable=1, no feed -> intr=1 at the 1st expiry, stage_out=1; timeout=1 at the 2nd expiry, 12 clocks after entering COUNT.
- Same setup, feed while count_out=2 after intr -> count_out=5, stage_out=0, intr=0; no timeout for the following 6 clocks.
- window_value=3, start_value=10, feed at count_out=7 -> early_fault=1, timeout=1 next cycle; feed at count_out=3 -> accepted normally.
- prescale=3, start_value=2 -> count_out decrements once every 4 clocks; expiry at clock 12.
- feed and expiry in the same cycle -> reload, no intr. update at count_out=1 after intr -> count_out=start_value, intr stays 1. enable=0 in TIMEOUT -> timeout=0, state IDLE.
- With WDT_LOCK_EN, after enabling, drive enable=0 and start_value=99 -> counter keeps running with the original value; rst_=1 pulse mid-count -> all outputs return to reset values asynchronously.
